// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one data-memory client (CPU load/store or debug/loader).
// The client drives the master side; the arbiter sits on the slave side.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous data memory between the CPU
// load/store port and a debug/loader port; one access per cycle, 1-cycle read latency.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ROW_D  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  dmem_arbiter_if.slave            cpu,
  output logic                     cpu_stall,
  dmem_arbiter_if.slave            dbg,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(ROW_D)-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam int IDX_W = $clog2(ROW_D);

  typedef enum logic {
    PORT_CPU,
    PORT_DBG
  } port_t;

  port_t last_gnt;
  logic  cpu_rvalid_q;
  logic  dbg_rvalid_q;
  logic  cpu_eff;
  logic  dbg_eff;
  logic  cpu_gnt;
  logic  dbg_gnt;
  logic  unused_addr;

  // Byte-lane and upper address bits play no part in the word index.
  assign unused_addr = ^{cpu.addr[31:IDX_W+2], cpu.addr[1:0],
                         dbg.addr[31:IDX_W+2], dbg.addr[1:0]};

  // A port is masked in its own data-return cycle, so a held load is not issued twice.
  always_comb begin
    cpu_eff   = cpu.req & ~cpu_rvalid_q & ~reset;
    dbg_eff   = dbg.req & ~dbg_rvalid_q & ~reset;
    cpu_gnt   = cpu_eff & (~dbg_eff | (last_gnt == PORT_DBG));
    dbg_gnt   = dbg_eff & ~cpu_gnt;
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu.we;
      mem_addr  = cpu.addr[IDX_W+1:2];
      mem_wdata = cpu.wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg.we;
      mem_addr  = dbg.addr[IDX_W+1:2];
      mem_wdata = dbg.wdata;
    end
    cpu_stall = cpu.req & ~(cpu_gnt & cpu.we) & ~cpu_rvalid_q & ~reset;
  end

  assign cpu.gnt    = cpu_gnt;
  assign dbg.gnt    = dbg_gnt;
  assign cpu.rvalid = cpu_rvalid_q;
  assign dbg.rvalid = dbg_rvalid_q;
  assign cpu.rdata  = cpu_rvalid_q ? mem_rdata : '0;
  assign dbg.rdata  = dbg_rvalid_q ? mem_rdata : '0;

  // Reset favours the CPU on the first tie and drops any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      last_gnt     <= PORT_DBG;
    end else begin
      cpu_rvalid_q <= cpu_gnt & ~cpu.we;
      dbg_rvalid_q <= dbg_gnt & ~dbg.we;
      if (cpu_gnt) begin
        last_gnt <= PORT_CPU;
      end else if (dbg_gnt) begin
        last_gnt <= PORT_DBG;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a per-cycle vector table plus hand-built reset sequences,
// with a reference memory and per-port queues predicting every read return.
module tb_dmem_arbiter;
  logic        clk;
  logic        reset;
  logic        mem_en;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_stall;
  logic [31:0] ram [32];

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [32];
  logic [31:0] cpu_q [$];
  logic [31:0] dbg_q [$];

  dmem_arbiter_if #(.DATA_W(32)) cpu_bus ();
  dmem_arbiter_if #(.DATA_W(32)) dbg_bus ();

  dmem_arbiter #(.DATA_W(32), .ROW_D(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_bus),
    .cpu_stall (cpu_stall),
    .dbg       (dbg_bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM standing in for the data memory.
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    string       name;
    logic        cr;
    logic        cw;
    logic [31:0] ca;
    logic [31:0] cd;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        ecg;
    logic        edg;
    logic        est;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input string name,
                              input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                              input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                              input logic ecg, input logic edg, input logic est);
    vec_t v;
    v.name = name;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ecg = ecg; v.edg = edg; v.est = est;
    return v;
  endfunction

  function automatic logic [4:0] idx_of(input logic [31:0] a);
    return a[6:2];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at posedge+1, check at the falling edge, update the model.
  task automatic apply_stimulus(input vec_t v);
    logic [31:0] exp;
    logic [4:0]  idx;
    cpu_bus.req = v.cr; cpu_bus.we = v.cw; cpu_bus.addr = v.ca; cpu_bus.wdata = v.cd;
    dbg_bus.req = v.dr; dbg_bus.we = v.dw; dbg_bus.addr = v.da; dbg_bus.wdata = v.dd;
    #4;
    if (cpu_q.size() > 0) begin
      exp = cpu_q.pop_front();
      check_output({v.name, "/cpu_rvalid"}, 32'(cpu_bus.rvalid), 32'd1);
      check_output({v.name, "/cpu_rdata"}, cpu_bus.rdata, exp);
    end else begin
      check_output({v.name, "/cpu_rvalid"}, 32'(cpu_bus.rvalid), 32'd0);
      check_output({v.name, "/cpu_rdata"}, cpu_bus.rdata, 32'd0);
    end
    if (dbg_q.size() > 0) begin
      exp = dbg_q.pop_front();
      check_output({v.name, "/dbg_rvalid"}, 32'(dbg_bus.rvalid), 32'd1);
      check_output({v.name, "/dbg_rdata"}, dbg_bus.rdata, exp);
    end else begin
      check_output({v.name, "/dbg_rvalid"}, 32'(dbg_bus.rvalid), 32'd0);
      check_output({v.name, "/dbg_rdata"}, dbg_bus.rdata, 32'd0);
    end
    check_output({v.name, "/cpu_gnt"}, 32'(cpu_bus.gnt), 32'(v.ecg));
    check_output({v.name, "/dbg_gnt"}, 32'(dbg_bus.gnt), 32'(v.edg));
    check_output({v.name, "/cpu_stall"}, 32'(cpu_stall), 32'(v.est));
    check_output({v.name, "/mem_en"}, 32'(mem_en), 32'(v.ecg | v.edg));
    if (v.ecg) begin
      idx = idx_of(v.ca);
      check_output({v.name, "/mem_addr"}, 32'(mem_addr), 32'(idx));
      check_output({v.name, "/mem_we"}, 32'(mem_we), 32'(v.cw));
      check_output({v.name, "/mem_wdata"}, mem_wdata, v.cd);
      if (v.cw) ref_mem[idx] = v.cd;
      else      cpu_q.push_back(ref_mem[idx]);
    end else if (v.edg) begin
      idx = idx_of(v.da);
      check_output({v.name, "/mem_addr"}, 32'(mem_addr), 32'(idx));
      check_output({v.name, "/mem_we"}, 32'(mem_we), 32'(v.dw));
      check_output({v.name, "/mem_wdata"}, mem_wdata, v.dd);
      if (v.dw) ref_mem[idx] = v.dd;
      else      dbg_q.push_back(ref_mem[idx]);
    end else begin
      check_output({v.name, "/mem_addr"}, 32'(mem_addr), 32'd0);
      check_output({v.name, "/mem_we"}, 32'(mem_we), 32'd0);
      check_output({v.name, "/mem_wdata"}, mem_wdata, 32'd0);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "/cpu_gnt"}, 32'(cpu_bus.gnt), 32'd0);
    check_output({tag, "/dbg_gnt"}, 32'(dbg_bus.gnt), 32'd0);
    check_output({tag, "/mem_en"}, 32'(mem_en), 32'd0);
    check_output({tag, "/mem_we"}, 32'(mem_we), 32'd0);
    check_output({tag, "/cpu_stall"}, 32'(cpu_stall), 32'd0);
    check_output({tag, "/cpu_rvalid"}, 32'(cpu_bus.rvalid), 32'd0);
    check_output({tag, "/dbg_rvalid"}, 32'(dbg_bus.rvalid), 32'd0);
    check_output({tag, "/cpu_rdata"}, cpu_bus.rdata, 32'd0);
    check_output({tag, "/dbg_rdata"}, dbg_bus.rdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

    //            name          cr cw ca       cd            dr dw da       dd            cg dg st
    vecs.push_back(mk("idle0",   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0));
    vecs.push_back(mk("st4",     1, 1, 32'h4,  32'h2,        0, 0, 32'h0,  32'h0,        1, 0, 0));
    vecs.push_back(mk("ld4",     1, 0, 32'h4,  32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 1));
    vecs.push_back(mk("ld4_ret", 1, 0, 32'h4,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0));
    vecs.push_back(mk("dwr0",    0, 0, 32'h0,  32'h0,        1, 1, 32'h0,  32'hf7f77f7f, 0, 1, 0));
    vecs.push_back(mk("dwr124",  0, 0, 32'h0,  32'h0,        1, 1, 32'd124, 32'h88888888, 0, 1, 0));
    vecs.push_back(mk("drd128",  0, 0, 32'h0,  32'h0,        1, 0, 32'd128, 32'h0,       0, 1, 0));
    vecs.push_back(mk("drd_ret", 0, 0, 32'h0,  32'h0,        1, 0, 32'd128, 32'h0,       0, 0, 0));
    vecs.push_back(mk("drd124",  0, 0, 32'h0,  32'h0,        1, 0, 32'd124, 32'h0,       0, 1, 0));
    vecs.push_back(mk("idle9",   0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0));
    vecs.push_back(mk("dwr_c",   0, 0, 32'h0,  32'h0,        1, 1, 32'hc,  32'hdeadbeef, 0, 1, 0));
    vecs.push_back(mk("ld_c",    1, 0, 32'hc,  32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 1));
    vecs.push_back(mk("ld_c_ret",1, 0, 32'hc,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0));
    vecs.push_back(mk("tie_rd",  1, 0, 32'h4,  32'h0,        1, 0, 32'hc,  32'h0,        0, 1, 1));
    vecs.push_back(mk("ovl_rd",  1, 0, 32'h4,  32'h0,        1, 0, 32'hc,  32'h0,        1, 0, 1));
    vecs.push_back(mk("ovl_rd2", 1, 0, 32'h4,  32'h0,        1, 0, 32'hc,  32'h0,        0, 1, 0));
    vecs.push_back(mk("st_wrap", 1, 1, 32'h87, 32'h5,        0, 0, 32'h0,  32'h0,        1, 0, 0));
    vecs.push_back(mk("ld_wrap", 1, 0, 32'h4,  32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 1));
    vecs.push_back(mk("ld_w_ret",1, 0, 32'h4,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0));

    // Power-on reset with both ports already requesting.
    reset = 1'b1;
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 32'h0; cpu_bus.wdata = 32'h0;
    dbg_bus.req = 1'b1; dbg_bus.we = 1'b0; dbg_bus.addr = 32'h0; dbg_bus.wdata = 32'h0;
    #2;
    check_reset_state("por");
    advance();
    check_reset_state("por_edge");
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      advance();
    end

    // Load granted, then reset lands before its data-return edge.
    apply_stimulus(mk("ld_kill", 1, 0, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 1));
    #2;
    reset = 1'b1;
    cpu_q.delete();
    dbg_q.delete();
    dbg_bus.req = 1'b1;
    #1;
    check_reset_state("rst_mid");
    advance();
    check_reset_state("rst_edge");
    reset = 1'b0;

    // Both ports writing continuously after reset: strict alternation, CPU first.
    apply_stimulus(mk("rr1", 1, 1, 32'h10, 32'h11, 1, 1, 32'h14, 32'h22, 1, 0, 0)); advance();
    apply_stimulus(mk("rr2", 1, 1, 32'h10, 32'h11, 1, 1, 32'h14, 32'h22, 0, 1, 1)); advance();
    apply_stimulus(mk("rr3", 1, 1, 32'h10, 32'h11, 1, 1, 32'h14, 32'h22, 1, 0, 0)); advance();
    apply_stimulus(mk("rr4", 1, 1, 32'h10, 32'h11, 1, 1, 32'h14, 32'h22, 0, 1, 1)); advance();
    apply_stimulus(mk("rb_cpu",  1, 0, 32'h10, 32'h0, 0, 0, 32'h0,  32'h0, 1, 0, 1)); advance();
    apply_stimulus(mk("rb_cret", 1, 0, 32'h10, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0)); advance();
    apply_stimulus(mk("rb_dbg",  0, 0, 32'h0,  32'h0, 1, 0, 32'h14, 32'h0, 0, 1, 0)); advance();
    apply_stimulus(mk("rb_dret", 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0)); advance();

    check_output("sb_drain", 32'(cpu_q.size() + dbg_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
